// File: rtl/mux_pkg.sv
// mux_pkg
// Shared definitions for the registered channel selector.
//   MODE_DIRECT / MODE_RR : values of the mode input
//   ch_lsb()              : bit offset of a channel slice inside a flattened
//                           multi-channel data bus
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Channel ch of width 'width' sits at bits [ch*width +: width].
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin search. Starting one position after ptr_i and
// wrapping, returns the first channel with an active request.
//   req_i   : per-channel request vector
//   ptr_i   : index of the last granted channel (lowest priority this cycle)
//   grant_o : index of the winning channel (0 when no request)
//   any_o   : at least one request is active
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] grant_o,
  output logic             any_o
);

  logic [SEL_W-1:0] idx;

  // Walk offsets 1..N_CH so ptr_i itself is visited last.
  always_comb begin
    idx     = '0;
    grant_o = '0;
    any_o   = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = SEL_W'((int'(ptr_i) + k) % N_CH);
      if (!any_o && req_i[idx]) begin
        any_o   = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/mux_sel_reg.sv
// mux_sel_reg
// N-channel selector with per-channel valid/ready and one output register
// stage (1-cycle latency, full throughput).
//   clk, rst   : clock, asynchronous active-high reset
//   mode       : 0 direct (sel chooses channel), 1 round-robin
//   sel        : channel index used in direct mode
//   in_valid   : per-channel valid
//   in_data    : flattened channel data, channel i at [i*DATA_W +: DATA_W]
//   in_ready   : per-channel ready (combinational, at most one bit set)
//   out_valid  : output register holds a word
//   out_data   : registered data
//   out_ch     : channel that supplied out_data
//   out_ready  : consumer accepts out_data
module mux_sel_reg
  import mux_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int N_CH   = 4,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready
);

  logic [DATA_W-1:0] ch_data [N_CH];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]  ptr_q,       ptr_d;

  logic [SEL_W-1:0]  rr_grant;
  logic              rr_any;
  logic              sel_in_range;
  logic [SEL_W-1:0]  cand_idx;
  logic              cand_ok;
  logic              load_en;
  logic              grant;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[ch_lsb(gi, DATA_W) +: DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req_i   (in_valid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .any_o   (rr_any)
  );

  // Extra bit keeps the comparison meaningful when N_CH is a power of two.
  assign sel_in_range = ({1'b0, sel} < (SEL_W+1)'(N_CH));

  always_comb begin
    if (mode == MODE_DIRECT) begin
      cand_idx = sel;
      cand_ok  = sel_in_range;
    end else begin
      cand_idx = rr_grant;
      cand_ok  = rr_any;
    end
  end

  // Register can take a word when empty or being drained this cycle.
  assign load_en = !out_valid_q || out_ready;
  assign grant   = load_en && cand_ok && in_valid[cand_idx];

  // Ready follows the candidate, not its valid: in direct mode the selected
  // channel sees ready even while idle.
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ready
      assign in_ready[gi] = load_en && cand_ok && (cand_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[cand_idx];
      out_ch_d    = cand_idx;
      if (mode == MODE_RR) begin
        ptr_d = cand_idx;
      end
    end else if (out_ready) begin
      // Drained with nothing to replace it; data/ch keep last values.
      out_valid_d = 1'b0;
    end
  end

  // ptr resets to the last channel so channel 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SEL_W'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_sel_reg.sv
module tb_mux_sel_reg;

  localparam int DW = 32;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [1:0]    sel;
  logic [NC-1:0] in_valid;
  logic [NC*DW-1:0] in_data;
  logic [NC-1:0] in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch;
  logic          out_ready;

  mux_sel_reg #(.DATA_W(DW), .N_CH(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    ch;
  } item_t;

  item_t q[$];
  int    ch_log[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Reference model state: output register occupancy and last RR winner.
  bit    full_m = 1'b0;
  int    ptr_m  = NC - 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", {63'd0, out_valid}, {63'd0, full_m});
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL out_unexpected: got ch %0d data 0x%0h expected no word", out_ch, out_data);
        end else begin
          check("out_data", {32'd0, out_data}, {32'd0, q[0].data});
          check("out_ch", {62'd0, out_ch}, {62'd0, q[0].ch});
          if (out_ready) begin
            $display("xfer ch=%0d data=0x%08h", out_ch, out_data);
            ch_log.push_back(int'(out_ch));
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic rand_data();
    for (int i = 0; i < NC; i++) in_data[i*DW +: DW] = $urandom();
  endtask

  // One cycle: drive at posedge+1, evaluate the model after the monitor has
  // sampled, then advance the model as the clock edge will.
  task automatic step(input logic m, input logic [1:0] s, input logic [NC-1:0] v, input logic r);
    bit       load, has, gnt;
    int       cand;
    logic [NC-1:0] exp_rdy;
    mode = m; sel = s; in_valid = v; out_ready = r;
    @(negedge clk); #1;
    load = !full_m || r;
    has  = 1'b0;
    cand = 0;
    if (m == 1'b0) begin
      has  = (int'(s) < NC);
      cand = int'(s);
    end else begin
      for (int k = 1; k <= NC; k++) begin
        int c;
        c = (ptr_m + k) % NC;
        if (!has && v[c]) begin
          has  = 1'b1;
          cand = c;
        end
      end
    end
    exp_rdy = (load && has) ? NC'(1 << cand) : '0;
    check("in_ready", {60'd0, in_ready}, {60'd0, exp_rdy});
    gnt = load && has && v[cand];
    if (gnt) begin
      q.push_back('{data: in_data[cand*DW +: DW], ch: 2'(cand)});
      full_m = 1'b1;
      if (m) ptr_m = cand;
    end else if (r) begin
      full_m = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_seq(input string name, input int exp_seq[$]);
    check({name, "_len"}, 64'(ch_log.size()), 64'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size(); i++) begin
      int got;
      got = (i < ch_log.size()) ? ch_log[i] : -1;
      check(name, 64'(got), 64'(exp_seq[i]));
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    #3;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_ch", {62'd0, out_ch}, 64'd0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Direct select of ch2.
    rand_data();
    in_data[2*DW +: DW] = 32'hDEADBEEF;
    step(1'b0, 2'd2, 4'b0100, 1'b1);
    // Direct select of idle ch1: ready without grant, output drains.
    step(1'b0, 2'd1, 4'b0000, 1'b1);
    step(1'b0, 2'd1, 4'b0000, 1'b1);

    // Round-robin from reset pointer: 0,1,2,3,0 back to back.
    ch_log.delete();
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step(1'b1, 2'd0, 4'b1111, 1'b1);
    end
    step(1'b1, 2'd0, 4'b0000, 1'b1);
    check_seq("rr_full", '{0, 1, 2, 3, 0});

    // Put ptr on 1, then 1010 alternates 3,1,3.
    rand_data();
    step(1'b1, 2'd0, 4'b0010, 1'b1);
    step(1'b1, 2'd0, 4'b0000, 1'b1);
    ch_log.delete();
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step(1'b1, 2'd0, 4'b1010, 1'b1);
    end
    step(1'b1, 2'd0, 4'b0000, 1'b1);
    check_seq("rr_1010", '{3, 1, 3});

    // Backpressure while holding 0x11.
    rand_data();
    in_data[0 +: DW] = 32'h11;
    step(1'b0, 2'd0, 4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step(1'($urandom()), 2'($urandom()), 4'($urandom()), 1'b0);
    end
    rand_data();
    step(1'b1, 2'd0, 4'b1111, 1'b1);
    step(1'b1, 2'd0, 4'b0000, 1'b1);

    // Asynchronous reset while FULL.
    rand_data();
    step(1'b0, 2'd3, 4'b1000, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_out_data", {32'd0, out_data}, 64'd0);
    check("arst_out_ch", {62'd0, out_ch}, 64'd0);
    q.delete();
    full_m = 1'b0;
    ptr_m  = NC - 1;
    in_valid = '0;
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    ch_log.delete();
    rand_data();
    step(1'b1, 2'd0, 4'b1111, 1'b1);
    step(1'b1, 2'd0, 4'b0000, 1'b1);
    check_seq("rr_after_rst", '{0});

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      step(1'($urandom()), 2'($urandom()), 4'($urandom()), ($urandom_range(0, 3) != 0));
    end

    step(1'b0, 2'd0, 4'b0000, 1'b1);
    step(1'b0, 2'd0, 4'b0000, 1'b1);
    check("final_queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
